uart_msg_tx: RTL

//  Transmit-side counterpart of the 8-byte UART message receiver: on a start pulse it latches

---
 rtl/uart_msg_tx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_msg_tx.sv
// -----------------------------------------------------------------------------
// uart_msg_tx
//
// Purpose:
//   Transmit side of the 8-byte UART message link. A start request latches
//   eight message bytes into an internal buffer and sends them back-to-back
//   as UART frames on tx: data0 first, LSB first, one start bit, eight data
//   bits, an optional even-parity bit and one stop bit. Each bit lasts
//   CLKS_PER_BIT cycles of clk_3125.
//
// Configuration:
//   UART_TX_PARITY_EN  defined     -> 8E1 frames (even-parity bit after bit 7)
//                      not defined -> 8N1 frames (no parity state, no parity logic)
//
// Ports:
//   clk_3125   in   3.125 MHz clock; all logic runs on its rising edge
//   rst        in   synchronous active-high reset (wins over start)
//   start      in   send request; acted on only while idle
//   data0..7   in   message bytes, data0 is sent first
//   tx         out  serial line, idle high (registered)
//   busy       out  high from the cycle after start is accepted until the
//                   final stop bit ends
//   done       out  one-cycle pulse when the stop bit of data7 completes
//   byte_idx   out  index of the byte on the line, 0 when idle
//   state_dbg  out  current FSM state encoding, for observation only
//
// Handshake: start is a level request with no ready. It is accepted on any
// clock edge where the FSM is IDLE and rst is low; while a message is in
// flight start is ignored and the buffer is not reloaded. Because the FSM is
// IDLE in the done cycle, a start held high repeats the message with exactly
// one idle-high cycle between messages.
// -----------------------------------------------------------------------------
module uart_msg_tx #(
   parameter int CLKS_PER_BIT = 27,
   parameter int NUM_BYTES    = 8
) (
   input  logic       clk_3125,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   input  logic [7:0] data2,
   input  logic [7:0] data3,
   input  logic [7:0] data4,
   input  logic [7:0] data5,
   input  logic [7:0] data6,
   input  logic [7:0] data7,
   output logic       tx,
   output logic       busy,
   output logic       done,
   output logic [2:0] byte_idx,
   output logic [2:0] state_dbg
);

   localparam int              BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      LAST_BYTE = 3'(NUM_BYTES - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START_BIT  = 3'd1,
      DATA_BITS  = 3'd2,
      PARITY_BIT = 3'd3,
      STOP_BIT   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA_BITS = 3'd2,
      STOP_BIT  = 3'd4
   } state_t;
`endif

   state_t            state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        msg_buf [NUM_BYTES];
   logic              baud_last;

   assign baud_last = (baud_cnt == BAUD_LAST);
   assign state_dbg = state;

   // tx is registered and always loaded with the value of the bit being
   // entered, so every bit occupies exactly CLKS_PER_BIT cycles on the pin.
   always_ff @(posedge clk_3125) begin
      if (rst) begin
         state    <= IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         byte_idx <= 3'd0;
         bit_cnt  <= 3'd0;
         baud_cnt <= '0;
         for (int i = 0; i < NUM_BYTES; i++) begin
            msg_buf[i] <= 8'h00;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx       <= 1'b1;
               busy     <= 1'b0;
               byte_idx <= 3'd0;
               bit_cnt  <= 3'd0;
               baud_cnt <= '0;
               if (start) begin
                  msg_buf[0] <= data0;
                  msg_buf[1] <= data1;
                  msg_buf[2] <= data2;
                  msg_buf[3] <= data3;
                  msg_buf[4] <= data4;
                  msg_buf[5] <= data5;
                  msg_buf[6] <= data6;
                  msg_buf[7] <= data7;
                  state      <= START_BIT;
                  tx         <= 1'b0;
                  busy       <= 1'b1;
               end
            end

            START_BIT: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= 3'd0;
                  tx       <= msg_buf[byte_idx][0];
                  state    <= DATA_BITS;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            DATA_BITS: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx    <= ^msg_buf[byte_idx];
                     state <= PARITY_BIT;
`else
                     tx    <= 1'b1;
                     state <= STOP_BIT;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= msg_buf[byte_idx][bit_cnt + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY_BIT: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= STOP_BIT;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif

            STOP_BIT: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (byte_idx == LAST_BYTE) begin
                     // Message complete: idle for at least this one cycle.
                     state    <= IDLE;
                     tx       <= 1'b1;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     byte_idx <= 3'd0;
                  end else begin
                     // Next byte's start bit follows with no idle gap.
                     byte_idx <= byte_idx + 3'd1;
                     tx       <= 1'b0;
                     state    <= START_BIT;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
